// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stalls, flushes,
// operand forwarding and saturating stall/redirect counters.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_use_rs1,
    input  logic             if_id_use_rs2,
    input  logic [4:0]       id_ex_rs1,
    input  logic [4:0]       id_ex_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic [4:0]       ex_mem_rd,
    input  logic             ex_mem_reg_wr,
    input  logic [4:0]       mem_wb_rd,
    input  logic             mem_wb_reg_wr,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, REDIRECT} state_t;

    localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

    state_t     state;
    logic [2:0] rcnt;
    logic       freeze;
    logic       redirect;
    logic       load_use;
    logic       take_redirect;

    assign freeze   = dmem_req & ~dmem_ready;
    assign redirect = ex_branch_taken | ex_jump;
    assign load_use = id_ex_mem_rd & (id_ex_rd != 5'd0) &
                      (((id_ex_rd == if_id_rs1) & if_id_use_rs1) |
                       ((id_ex_rd == if_id_rs2) & if_id_use_rs2));
    assign take_redirect = ~freeze & (state == RUN) & redirect;

    // Priority: memory freeze, then redirect shadow, then new redirect, then load-use.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state == REDIRECT) begin
            if_id_flush = 1'b1;
        end else if (redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        fwd_a_sel = 2'b00;
        if (ex_mem_reg_wr && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs1)
            fwd_a_sel = 2'b10;
        else if (mem_wb_reg_wr && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs1)
            fwd_a_sel = 2'b01;
    end

    always_comb begin
        fwd_b_sel = 2'b00;
        if (ex_mem_reg_wr && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs2)
            fwd_b_sel = 2'b10;
        else if (mem_wb_reg_wr && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs2)
            fwd_b_sel = 2'b01;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            rcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!freeze) begin
                case (state)
                    RUN: begin
                        if (redirect && FC != 3'd0) begin
                            state <= REDIRECT;
                            rcnt  <= FC;
                        end
                    end
                    REDIRECT: begin
                        rcnt <= rcnt - 3'd1;
                        if (rcnt == 3'd1)
                            state <= RUN;
                    end
                    default: state <= RUN;
                endcase
            end
            if (pc_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (take_redirect && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline. It generates stall, flush/bubble and forwarding controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken branches and jumps, and multi-cycle data-memory waits, and keeps saturating performance counters.

Parameters:
FLUSH_CYCLES, 1, extra cycles the IF/ID flush is held after a redirect to cover synchronous imem latency; range 0..7
CNT_W, 16, width of the performance counters

Ports:
CLK  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
if_id_rs1  input  5  rs1 of the instruction in ID
if_id_rs2  input  5  rs2 of the instruction in ID
if_id_use_rs1  input  1  ID instruction reads rs1
if_id_use_rs2  input  1  ID instruction reads rs2
id_ex_rs1  input  5  rs1 of the instruction in EX
id_ex_rs2  input  5  rs2 of the instruction in EX
id_ex_rd  input  5  rd of the instruction in EX
id_ex_mem_rd  input  1  EX instruction is a load
ex_branch_taken  input  1  branch resolved taken in EX
ex_jump  input  1  JAL/JALR in EX
ex_mem_rd  input  5  rd in MEM
ex_mem_reg_wr  input  1  MEM instruction writes rd
mem_wb_rd  input  5  rd in WB
mem_wb_reg_wr  input  1  WB instruction writes rd
dmem_req  input  1  MEM stage has an active data access
dmem_ready  input  1  data memory completes the access this cycle
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  load NOP into IF/ID
id_ex_stall  output  1  hold ID/EX
id_ex_flush  output  1  load bubble (all control fields 0) into ID/EX
ex_mem_stall  output  1  hold EX/MEM
mem_wb_flush  output  1  load bubble into MEM/WB
fwd_a_sel  output  2  EX operand A source: 00 regfile, 01 MEM/WB, 10 EX/MEM
fwd_b_sel  output  2  EX operand B source, same encoding
stall_cnt  output  CNT_W  saturating count of cycles with pc_stall=1
flush_cnt  output  CNT_W  saturating count of redirect events

Behaviour:
- Reset (async, rst_n=0): FSM=RUN, redirect counter=0, stall_cnt=0, flush_cnt=0. Stall and flush outputs are combinational and read 0 in RUN with idle inputs. fwd_*_sel read 00 when no match.
- freeze = dmem_req & ~dmem_ready. It is a combinational override and has the highest priority in every state:
  - pc_stall=if_id_stall=id_ex_stall=ex_mem_stall=1, mem_wb_flush=1, if_id_flush=id_ex_flush=0.
  - The FSM state and redirect counter hold.
  - The freeze is released in the same cycle that dmem_ready=1.
- redirect = ex_branch_taken | ex_jump.
- load_use = id_ex_mem_rd & (id_ex_rd!=0) & ((id_ex_rd==if_id_rs1 & if_id_use_rs1) | (id_ex_rd==if_id_rs2 & if_id_use_rs2)).
- FSM states RUN and REDIRECT. The redirect counter is 3 bits.
- RUN, no freeze, redirect: if_id_flush=1, id_ex_flush=1, pc_stall=0 (PC takes the target). flush_cnt increments by 1.
  - If FLUSH_CYCLES>0: next state REDIRECT, counter=FLUSH_CYCLES.
  - Otherwise the FSM stays in RUN.
  - Redirect beats load_use in the same cycle: no stall.
- RUN, no freeze, load_use, no redirect: pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle. The next cycle the bubble in EX clears the hazard.
- REDIRECT, no freeze: if_id_flush=1, pc_stall=0. Counter decrements; at counter==1, next state is RUN.
  - redirect and load_use inputs are ignored (EX holds a bubble, ID holds a NOP).
- Forwarding (combinational, all states), fwd_a_sel:
  - 10 if ex_mem_reg_wr & ex_mem_rd!=0 & ex_mem_rd==id_ex_rs1;
  - else 01 if mem_wb_reg_wr & mem_wb_rd!=0 & mem_wb_rd==id_ex_rs1;
  - else 00.
  - fwd_b_sel uses id_ex_rs2 with the same rules. EX/MEM always beats MEM/WB.
- A register with index x0 never forwards and never triggers a stall.
- stall_cnt increments on every clock edge where pc_stall=1; flush_cnt increments on accepted redirects. Both saturate at all-ones.
- Reset mid-freeze or mid-REDIRECT returns the block immediately to RUN with counters cleared.

Test Plan:
- Load x5 in EX, ID reads x5 (use_rs1=1) -> one cycle of pc_stall=if_id_stall=id_ex_flush=1, then all 0; stall_cnt=1. Same case with rd=x0 -> no stall.
- ex_branch_taken=1 with FLUSH_CYCLES=1 -> cycle0: if_id_flush=id_ex_flush=1; cycle1: if_id_flush=1 only; cycle2: RUN, all 0; flush_cnt=1.
- dmem_req=1, dmem_ready=0 for 3 cycles while ex_branch_taken=1 -> 3 cycles of full stall with mem_wb_flush=1 and no flush. In the cycle dmem_ready=1 the redirect is taken (if_id_flush=id_ex_flush=1); stall_cnt=3.
- ex_mem_rd=mem_wb_rd=x7, both write, id_ex_rs1=id_ex_rs2=x7 -> fwd_a_sel=fwd_b_sel=10. Clear ex_mem_reg_wr -> 01. Set rd=x0 -> 00.
- Load-use and ex_jump in the same cycle -> no pc_stall; if_id_flush=id_ex_flush=1; flush_cnt +1.
- Force stall_cnt to all-ones via a long freeze (CNT_W=4, 20 cycles) -> holds at 15. Assert rst_n=0 mid-freeze -> counters 0, state RUN asynchronously.
